// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one bit pair per clock, LSB first, through a
// single full-adder cell, with the carry held in a flop between bits.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic               load;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   sum_sh;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic               fa_s;
  logic               fa_co;
  logic               last_bit;

  // Full-adder cell fed straight from the operand shift registers
  always_comb begin
    fa_s  = a_sh[0] ^ b_sh[0] ^ carry;
    fa_co = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
  end

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          load      = 1'b1;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        // A start here chains the next operation without an idle gap
        if (start) begin
          state_nxt = RUN;
          load      = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        a_sh   <= a;
        b_sh   <= b;
        carry  <= cin;
        cnt    <= '0;
        sum_sh <= '0;
      end else if (state == RUN) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
        carry  <= fa_co;
        cnt    <= cnt + CNT_W'(1);
        // The final bit is merged directly into the published result
        if (last_bit) begin
          sum  <= {fa_s, sum_sh[WIDTH-1:1]};
          cout <= fa_co;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: vector table, corner-case sequences,
// random operands against an arithmetic model, and an exhaustive WIDTH=2 sweep.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic       cin;
  logic       busy, done;
  logic [7:0] sum;
  logic       cout;

  logic       start2;
  logic [1:0] a2, b2;
  logic       cin2;
  logic       busy2, done2;
  logic [1:0] sum2;
  logic       cout2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {8'd0, c};
  endfunction

  // One complete operation on the 8-bit instance; lat counts edges after the start edge
  task automatic run_op(input logic [7:0] xa, input logic [7:0] xb, input logic xc,
                        output logic [7:0] s, output logic c, output int lat,
                        output int busy_n, output int overlap);
    s = '0; c = 1'b0; lat = -1; busy_n = 0; overlap = 0;
    @(posedge clk); #1;
    a = xa; b = xb; cin = xc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = ~xa; b = ~xb; cin = ~xc;
    if (busy) busy_n++;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (busy && done) overlap++;
      if (busy) busy_n++;
      if (done) begin
        lat = k;
        s = sum;
        c = cout;
        break;
      end
    end
  endtask

  task automatic run_op2(input logic [1:0] xa, input logic [1:0] xb, input logic xc,
                         output logic [1:0] s, output logic c, output int lat);
    s = '0; c = 1'b0; lat = -1;
    @(posedge clk); #1;
    a2 = xa; b2 = xb; cin2 = xc; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done2) begin
        lat = k;
        s = sum2;
        c = cout2;
        break;
      end
    end
  endtask

  initial begin
    logic [7:0] s;
    logic       c;
    logic [8:0] m;
    int         lat, busy_n, overlap, ndone, t1, t2;
    logic [7:0] s1, s2;
    logic       c1, c2;
    logic [1:0] s2w;
    logic       c2w;
    logic [2:0] m2;

    tbl[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tbl[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    tbl[3] = '{8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0};
    tbl[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tbl[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    tbl[6] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0};
    tbl[7] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_sum", sum, 0);
    chk("reset_cout", cout, 0);
    // start during reset is dropped
    start = 1'b1; a = 8'h11; b = 8'h22;
    @(posedge clk); #1;
    start = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_wins_busy", busy, 0);

    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].cin, s, c, lat, busy_n, overlap);
      chk($sformatf("tbl%0d_sum", i), s, tbl[i].sum);
      chk($sformatf("tbl%0d_cout", i), c, tbl[i].cout);
      chk($sformatf("tbl%0d_lat", i), lat, 8);
      chk($sformatf("tbl%0d_busy", i), busy_n, 8);
      chk($sformatf("tbl%0d_overlap", i), overlap, 0);
    end

    // Result holds through idle cycles
    run_op(8'hFF, 8'h01, 1'b0, s, c, lat, busy_n, overlap);
    chk("hold_lat", lat, 8);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("hold_sum", sum, 8'h00);
      chk("hold_cout", cout, 1);
      chk("hold_done", done, 0);
    end

    // Start and operand changes during RUN are ignored
    @(posedge clk); #1;
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; s = '0; c = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        s = sum;
        c = cout;
      end
    end
    chk("ign_ndone", ndone, 1);
    chk("ign_sum", s, 8'h46);
    chk("ign_cout", c, 0);
    chk("ign_idle", busy, 0);

    // Reset mid-RUN aborts and clears the result
    @(posedge clk); #1;
    a = 8'hF0; b = 8'h0F; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_busy_before", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout", cout, 0);
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("abort_ndone", ndone, 0);
    run_op(8'hF0, 8'h0F, 1'b0, s, c, lat, busy_n, overlap);
    chk("after_abort_sum", s, 8'hFF);
    chk("after_abort_cout", c, 0);
    chk("after_abort_lat", lat, 8);

    // Back-to-back with start held high
    @(posedge clk); #1;
    a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 8'h01; b = 8'h02; cin = 1'b1;
    t1 = -1; t2 = -1; s1 = '0; s2 = '0; c1 = 1'b0; c2 = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (done) begin
        if (t1 < 0) begin
          t1 = k; s1 = sum; c1 = cout;
        end else begin
          t2 = k; s2 = sum; c2 = cout;
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    chk("b2b_t1", t1, 8);
    chk("b2b_gap", t2 - t1, 9);
    chk("b2b_sum1", s1, 8'h00);
    chk("b2b_cout1", c1, 1);
    chk("b2b_sum2", s2, 8'h04);
    chk("b2b_cout2", c2, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("b2b_idle", busy | done, 0);

    // Random operands against the arithmetic model
    for (int i = 0; i < 30; i++) begin
      logic [7:0] ra, rb;
      logic       rc;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      m = model(ra, rb, rc);
      run_op(ra, rb, rc, s, c, lat, busy_n, overlap);
      chk($sformatf("rnd%0d_sum a=%0h b=%0h c=%0d", i, ra, rb, rc), s, m[7:0]);
      chk($sformatf("rnd%0d_cout", i), c, m[8]);
      chk($sformatf("rnd%0d_lat", i), lat, 8);
    end

    // Exhaustive WIDTH=2
    for (int ia = 0; ia < 4; ia++) begin
      for (int ib = 0; ib < 4; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          m2 = 3'(ia) + 3'(ib) + 3'(ic);
          run_op2(2'(ia), 2'(ib), 1'(ic), s2w, c2w, lat);
          chk($sformatf("w2 %0d+%0d+%0d", ia, ib, ic), {c2w, s2w}, m2);
          chk($sformatf("w2 lat %0d+%0d+%0d", ia, ib, ic), lat, 2);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
